ddr_wr_arbiter: RTL and testbench
=================================

# ddr_wr_arbiter

Two-requester write-channel arbiter for the DDR controller's AXI write port, running in the DDR clock domain. It shares the single AW/W port between requester 0 (RISC-V ICB bridge path) and requester 1 (streaming capture path). It grants one burst at a time, round-robin or fixed-priority, and sequences the address phase and the beat-counted data phase. Each requester sees a simple command/data handshake. The DDR side sees one burst in flight at a time.

## Interface
- ADDR_W, 28, DDR byte address width
- DATA_W, 256, DDR data width (32 bytes per beat)
- ddr_clk  in  1  DDR user clock; only clock
- ddr_rst  in  1  reset, asynchronous, active-high
- arb_mode  in  1  0 = round-robin, 1 = fixed priority (req0 wins); sampled in IDLE only
- reqN_cmd_valid  in  1  (N=0,1) burst request; held until reqN_cmd_ready
- reqN_cmd_addr  in  ADDR_W  burst start byte address
- reqN_cmd_len  in  4  beats minus 1 (0 = 1 beat, 15 = 16 beats)
- reqN_cmd_ready  out  1  one-cycle pulse: this requester's command accepted by DDR
- reqN_wdata  in  DATA_W  current beat, valid whenever the requester has a pending burst
- reqN_wstrb  in  DATA_W/8  byte enables for current beat
- reqN_wready  out  1  beat consumed this cycle; requester advances to next beat
- ddr_axi_awaddr  out  ADDR_W  registered burst address, bits [4:0] forced 0
- ddr_axi_awuser_id  out  4  registered, {3'b000, granted index}
- ddr_axi_awlen  out  4  registered, granted reqN_cmd_len
- ddr_axi_awvalid  out  1  registered
- ddr_axi_awready  in  1  controller accepts address
- ddr_axi_wdata  out  DATA_W  combinational mux of granted reqN_wdata; 0 when not in DATA
- ddr_axi_wstrb  out  DATA_W/8  combinational mux of granted reqN_wstrb; 0 when not in DATA
- ddr_axi_wready  in  1  controller takes a beat this cycle (no wvalid on this controller)
- grant  out  2  one-hot current owner, 0 in IDLE
- busy  out  1  high in ADDR or DATA

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: if any reqN_cmd_valid, pick a winner.
  - arb_mode=1: req0 wins over req1.
  - arb_mode=0: the requester not granted last wins a tie; a single requester always wins.
  - On the winner: latch awaddr (low 5 bits cleared), awlen, awuser_id and grant; set awvalid=1; set beat_cnt=0; go to ADDR.
- ADDR: hold awvalid and all AW fields stable until ddr_axi_awready=1.
  - On the handshake: awvalid<=0, reqN_cmd_ready pulses 1 for the granted N (same cycle as the handshake, combinational), update last_grant, go to DATA.
- DATA: reqN_wready = grant[N] & ddr_axi_wready. Each beat with wready increments the 4-bit beat_cnt.
  - The beat where beat_cnt == awlen and wready=1 is the last beat: next state IDLE, grant cleared.
- ddr_axi_wready outside DATA is ignored; no reqN_wready is asserted.
- A request deasserted while not granted is simply not considered. Requesters must not drop cmd_valid once it is high; this is not checked.
- A new arbitration never starts before the current burst's last beat completes (one burst in flight).

## Timing
- Reset (async assert, sync use after release): state=IDLE, awvalid=0, awaddr=0, awlen=0, awuser_id=0, grant=0, busy=0, beat_cnt=0, last_grant=1 (so req0 wins the first tie).
  - All cmd_ready, wready, wdata and wstrb outputs are 0 during and after reset.
- Request to awvalid: reqN_cmd_valid high at edge k gives awvalid=1 after edge k+1. Minimum latency 1 cycle.
- awready high in the first ADDR cycle gives cmd_ready in that cycle and DATA from the next cycle.
- Minimum burst occupancy: 1 (IDLE) + 1 (ADDR) + (awlen+1) DATA cycles, assuming awready and wready are always high.
- Back-to-back: after the last beat, IDLE takes one cycle, so there is a 1-cycle bubble between bursts.
- Reset asserted mid-burst: the burst is abandoned; no further cmd_ready or wready. Requesters reset via their own domain logic.
- beat_cnt compare is 4-bit: awlen=15 gives exactly 16 beats; the counter does not wrap into extra beats.

## Test plan
- Single req0, addr=0x000_1234, len=0, awready/wready always 1:
  - awaddr=0x000_1220, awlen=0, awuser_id=0.
  - One req0_wready pulse; ddr_axi_wdata equals req0_wdata on that cycle.
  - busy for 2 cycles.
- Both requesters valid continuously, arb_mode=0, len=3:
  - Grants alternate 0,1,0,1.
  - Each burst has exactly 4 wready beats to its owner and none to the other.
  - awuser_id matches the owner.
- Both valid, arb_mode=1: req0 granted every burst while valid; req1 is granted only after req0_cmd_valid drops.
- awready held low 5 cycles, then high:
  - awvalid, awaddr and awlen are stable for all 6 cycles.
  - cmd_ready is a single pulse on the handshake cycle.
  - wready asserted during ADDR produces no reqN_wready.
- len=15 with wready toggling 1,0,1,0: exactly 16 beats, completing in 31 DATA cycles; then IDLE, grant=0.
- ddr_rst pulsed during beat 2 of a 4-beat burst: all outputs go to reset values immediately; after release, the first tie goes to req0.

Source files
------------

// File: rtl/ddr_wr_arbiter.sv
// Two-requester write arbiter for the DDR AXI write port: picks one burst at a time
// (round-robin or fixed priority), then runs the address phase and a beat-counted data phase.
module ddr_wr_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 256
) (
    input  logic                  ddr_clk,
    input  logic                  ddr_rst,
    input  logic                  arb_mode,

    input  logic                  req0_cmd_valid,
    input  logic [ADDR_W-1:0]     req0_cmd_addr,
    input  logic [3:0]            req0_cmd_len,
    output logic                  req0_cmd_ready,
    input  logic [DATA_W-1:0]     req0_wdata,
    input  logic [DATA_W/8-1:0]   req0_wstrb,
    output logic                  req0_wready,

    input  logic                  req1_cmd_valid,
    input  logic [ADDR_W-1:0]     req1_cmd_addr,
    input  logic [3:0]            req1_cmd_len,
    output logic                  req1_cmd_ready,
    input  logic [DATA_W-1:0]     req1_wdata,
    input  logic [DATA_W/8-1:0]   req1_wstrb,
    output logic                  req1_wready,

    output logic [ADDR_W-1:0]     ddr_axi_awaddr,
    output logic [3:0]            ddr_axi_awuser_id,
    output logic [3:0]            ddr_axi_awlen,
    output logic                  ddr_axi_awvalid,
    input  logic                  ddr_axi_awready,
    output logic [DATA_W-1:0]     ddr_axi_wdata,
    output logic [DATA_W/8-1:0]   ddr_axi_wstrb,
    input  logic                  ddr_axi_wready,

    output logic [1:0]            grant,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    // Bursts are 32-byte aligned on the DDR side.
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(5'h1f));

    logic [1:0]        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [3:0]        awlen_q, awlen_d;
    logic [3:0]        awuser_q, awuser_d;
    logic              awvalid_q, awvalid_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;
    logic              last_grant_q, last_grant_d;

    logic win0, win1;
    logic addr_phase, data_phase;

    // req0 takes a tie unless round-robin and it was the previous owner.
    assign win0 = req0_cmd_valid & (~req1_cmd_valid | arb_mode | last_grant_q);
    assign win1 = req1_cmd_valid & ~win0;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        awaddr_d     = awaddr_q;
        awlen_d      = awlen_q;
        awuser_d     = awuser_q;
        awvalid_d    = awvalid_q;
        beat_cnt_d   = beat_cnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (win0 | win1) begin
                    state_d    = S_ADDR;
                    grant_d    = {win1, win0};
                    awaddr_d   = (win1 ? req1_cmd_addr : req0_cmd_addr) & ADDR_MASK;
                    awlen_d    = win1 ? req1_cmd_len : req0_cmd_len;
                    awuser_d   = {3'b000, win1};
                    awvalid_d  = 1'b1;
                    beat_cnt_d = 4'd0;
                end
            end
            S_ADDR: begin
                if (ddr_axi_awready) begin
                    state_d      = S_DATA;
                    awvalid_d    = 1'b0;
                    last_grant_d = grant_q[1];
                end
            end
            S_DATA: begin
                if (ddr_axi_wready) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    if (beat_cnt_q == awlen_q) begin
                        state_d = S_IDLE;
                        grant_d = 2'b00;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge ddr_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'b00;
            awaddr_q     <= '0;
            awlen_q      <= 4'd0;
            awuser_q     <= 4'd0;
            awvalid_q    <= 1'b0;
            beat_cnt_q   <= 4'd0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            awaddr_q     <= awaddr_d;
            awlen_q      <= awlen_d;
            awuser_q     <= awuser_d;
            awvalid_q    <= awvalid_d;
            beat_cnt_q   <= beat_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign addr_phase = (state_q == S_ADDR);
    assign data_phase = (state_q == S_DATA);

    assign req0_cmd_ready = addr_phase & ddr_axi_awready & grant_q[0];
    assign req1_cmd_ready = addr_phase & ddr_axi_awready & grant_q[1];
    assign req0_wready    = data_phase & ddr_axi_wready & grant_q[0];
    assign req1_wready    = data_phase & ddr_axi_wready & grant_q[1];

    assign ddr_axi_wdata = !data_phase ? '0 : (grant_q[1] ? req1_wdata : req0_wdata);
    assign ddr_axi_wstrb = !data_phase ? '0 : (grant_q[1] ? req1_wstrb : req0_wstrb);

    assign ddr_axi_awaddr    = awaddr_q;
    assign ddr_axi_awuser_id = awuser_q;
    assign ddr_axi_awlen     = awlen_q;
    assign ddr_axi_awvalid   = awvalid_q;
    assign grant             = grant_q;
    assign busy              = state_q != S_IDLE;

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Scoreboard bench for ddr_wr_arbiter: scenarios queue the expected AW order, a
// per-cycle monitor pops and checks address, handshake, beat routing and data.
module tb_ddr_wr_arbiter;
    localparam int AW = 28;
    localparam int DW = 256;
    localparam int SW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          arb_mode;
    logic [1:0]    cmd_valid;
    logic [AW-1:0] cmd_addr [2];
    logic [3:0]    cmd_len [2];
    logic [DW-1:0] wdata_i [2];
    logic [SW-1:0] wstrb_i [2];
    logic          r0_cmd_ready, r1_cmd_ready, r0_wready, r1_wready;
    logic [AW-1:0] awaddr;
    logic [3:0]    awuser_id, awlen;
    logic          awvalid, awready;
    logic [DW-1:0] axi_wdata;
    logic [SW-1:0] axi_wstrb;
    logic          axi_wready;
    logic [1:0]    grant;
    logic          busy;

    wire [1:0] cmd_ready = {r1_cmd_ready, r0_cmd_ready};
    wire [1:0] wready_o  = {r1_wready, r0_wready};

    ddr_wr_arbiter dut (
        .ddr_clk(clk), .ddr_rst(rst), .arb_mode(arb_mode),
        .req0_cmd_valid(cmd_valid[0]), .req0_cmd_addr(cmd_addr[0]), .req0_cmd_len(cmd_len[0]),
        .req0_cmd_ready(r0_cmd_ready), .req0_wdata(wdata_i[0]), .req0_wstrb(wstrb_i[0]),
        .req0_wready(r0_wready),
        .req1_cmd_valid(cmd_valid[1]), .req1_cmd_addr(cmd_addr[1]), .req1_cmd_len(cmd_len[1]),
        .req1_cmd_ready(r1_cmd_ready), .req1_wdata(wdata_i[1]), .req1_wstrb(wstrb_i[1]),
        .req1_wready(r1_wready),
        .ddr_axi_awaddr(awaddr), .ddr_axi_awuser_id(awuser_id), .ddr_axi_awlen(awlen),
        .ddr_axi_awvalid(awvalid), .ddr_axi_awready(awready),
        .ddr_axi_wdata(axi_wdata), .ddr_axi_wstrb(axi_wstrb), .ddr_axi_wready(axi_wready),
        .grant(grant), .busy(busy)
    );

    typedef struct {
        int            id;
        logic [AW-1:0] addr;
        logic [3:0]    len;
    } aw_t;

    int vectors = 0;
    int miscompares = 0;

    aw_t exp_q[$];
    int  grant_log[$];

    // requester model
    int            rem [2];
    int            bidx [2];
    int            lenv [2];
    logic [AW-1:0] base [2];

    // data-phase tracking
    int d_owner = -1;
    int d_beat, d_len, d_burst, d_cycles;
    int last_data_cycles, wr_pulses, cr_pulses, busy_cycles, cyc, first_aw;
    int aw_delay = 0;
    int aw_wait = 0;
    int wr_toggle = 0;
    logic          aw_held = 1'b0;
    logic [AW+7:0] held;

    function automatic logic [DW-1:0] data_of(int r, int b, int beat);
        logic [31:0] w;
        w = 32'hC0DE0000 ^ 32'(r << 12) ^ 32'(b << 4) ^ 32'(beat);
        return {4{w, ~w}};
    endfunction

    function automatic logic [SW-1:0] strb_of(int r, int b, int beat);
        return 32'hF0F00000 ^ 32'(r << 20) ^ 32'(b << 8) ^ 32'(beat * 3);
    endfunction

    function automatic logic [AW-1:0] addr_of(int r, int b);
        return base[r] + AW'(b * 32'h800);
    endfunction

    task automatic setup(input logic mode, input int n0, input int n1, input int l0, input int l1,
                         input logic [AW-1:0] b0, input logic [AW-1:0] b1);
        arb_mode = mode;
        rem[0] = n0;   rem[1] = n1;
        lenv[0] = l0;  lenv[1] = l1;
        base[0] = b0;  base[1] = b1;
        bidx[0] = 0;   bidx[1] = 0;
    endtask

    task automatic push_exp(input int id, input int b);
        logic [AW-1:0] a;
        a = addr_of(id, b);
        exp_q.push_back('{id, {a[AW-1:5], 5'b00000}, 4'(lenv[id])});
    endtask

    task automatic drive_inputs();
        for (int r = 0; r < 2; r++) begin
            cmd_valid[r] = (rem[r] > 0);
            cmd_addr[r]  = addr_of(r, bidx[r]);
            cmd_len[r]   = 4'(lenv[r]);
            if (d_owner == r) begin
                wdata_i[r] = data_of(r, d_burst, d_beat);
                wstrb_i[r] = strb_of(r, d_burst, d_beat);
            end else begin
                wdata_i[r] = data_of(r, bidx[r], 0);
                wstrb_i[r] = strb_of(r, bidx[r], 0);
            end
        end
    endtask

    // One clock: set ready inputs, sample away from the edge, check, advance the model.
    task automatic cycle();
        aw_t          cur;
        logic         hs;
        int           hs_id;
        logic [1:0]   exp_cr, exp_wr;
        logic [DW-1:0] exp_d;
        logic [SW-1:0] exp_s;
        @(negedge clk);
        if (awvalid) begin
            awready = (aw_wait >= aw_delay);
            aw_wait++;
        end else begin
            awready = 1'b1;
        end
        axi_wready = (wr_toggle != 0 && d_owner >= 0) ? (d_cycles % 2 == 0) : 1'b1;
        #1;
        cyc++;
        if (busy) busy_cycles++;
        if (awvalid && first_aw < 0) first_aw = cyc;
        if (cmd_ready != 2'b00) cr_pulses++;
        if (wready_o != 2'b00) wr_pulses++;
        hs = awvalid && awready;
        hs_id = -1;
        exp_cr = 2'b00;
        if (hs) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_aw: awuser_id=%0d awaddr=%h, required no burst", awuser_id, awaddr);
            end else begin
                cur = exp_q.pop_front();
                hs_id = cur.id;
                exp_cr[cur.id] = 1'b1;
                if ({awuser_id, awaddr, awlen} !== {4'(cur.id), cur.addr, cur.len}) begin
                    miscompares++;
                    $display("FAIL aw_fields: id=%0d addr=%h len=%0d, required id=%0d addr=%h len=%0d",
                             awuser_id, awaddr, awlen, cur.id, cur.addr, cur.len);
                end
                vectors++;
                if (grant !== 2'(1 << cur.id)) begin
                    miscompares++;
                    $display("FAIL grant_addr: grant=%b, required %b", grant, 2'(1 << cur.id));
                end
            end
        end
        if (awvalid) begin
            if (aw_held) begin
                vectors++;
                if ({awaddr, awlen, awuser_id} !== held) begin
                    miscompares++;
                    $display("FAIL aw_stable: %h, required %h", {awaddr, awlen, awuser_id}, held);
                end
            end else begin
                held = {awaddr, awlen, awuser_id};
                aw_held = 1'b1;
            end
        end
        vectors++;
        if (cmd_ready !== exp_cr) begin
            miscompares++;
            $display("FAIL cmd_ready: %b, required %b", cmd_ready, exp_cr);
        end
        exp_wr = (d_owner >= 0 && axi_wready) ? 2'(1 << d_owner) : 2'b00;
        vectors++;
        if (wready_o !== exp_wr) begin
            miscompares++;
            $display("FAIL wready: %b, required %b", wready_o, exp_wr);
        end
        if (d_owner >= 0) begin
            exp_d = data_of(d_owner, d_burst, d_beat);
            exp_s = strb_of(d_owner, d_burst, d_beat);
            vectors++;
            if (grant !== 2'(1 << d_owner) || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL grant_data: grant=%b busy=%b, required grant=%b busy=1",
                         grant, busy, 2'(1 << d_owner));
            end
        end else begin
            exp_d = '0;
            exp_s = '0;
        end
        vectors++;
        if ({axi_wdata, axi_wstrb} !== {exp_d, exp_s}) begin
            miscompares++;
            $display("FAIL wdata: data=%h strb=%h, required data=%h strb=%h", axi_wdata, axi_wstrb, exp_d, exp_s);
        end
        if (d_owner < 0 && !awvalid) begin
            vectors++;
            if (busy !== 1'b0 || grant !== 2'b00) begin
                miscompares++;
                $display("FAIL idle: busy=%b grant=%b, required busy=0 grant=00", busy, grant);
            end
        end
        if (d_owner >= 0) begin
            d_cycles++;
            if (axi_wready) begin
                if (d_beat == d_len) begin
                    last_data_cycles = d_cycles;
                    d_owner = -1;
                end else begin
                    d_beat++;
                end
            end
        end
        if (hs_id >= 0) begin
            d_owner = hs_id;
            d_beat = 0;
            d_len = int'(cur.len);
            d_burst = bidx[hs_id];
            d_cycles = 0;
            bidx[hs_id]++;
            rem[hs_id]--;
            grant_log.push_back(hs_id);
        end
        if (hs) begin
            aw_wait = 0;
            aw_held = 1'b0;
        end
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic run(input int max_cycles);
        bit done;
        cyc = -1; first_aw = -1; busy_cycles = 0; wr_pulses = 0; cr_pulses = 0;
        grant_log.delete();
        drive_inputs();
        done = 0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            cycle();
            done = (rem[0] == 0 && rem[1] == 0 && d_owner < 0 && exp_q.size() == 0);
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: %0d bursts still queued, required 0 within %0d cycles", exp_q.size(), max_cycles);
            exp_q.delete();
        end
        cycle();
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if ({awvalid, awaddr, awlen, awuser_id, grant, busy, cmd_ready, wready_o, axi_wdata, axi_wstrb} !== '0) begin
            miscompares++;
            $display("FAIL %s: awvalid=%b awaddr=%h awlen=%0d id=%0d grant=%b busy=%b cr=%b wr=%b strb=%h, required all 0",
                     name, awvalid, awaddr, awlen, awuser_id, grant, busy, cmd_ready, wready_o, axi_wstrb);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; awready = 1'b1; axi_wready = 1'b1;
        setup(1'b0, 0, 0, 0, 0, 28'h0, 28'h0);
        drive_inputs();
        cmd_valid = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;
        drive_inputs();
        $display("test_reset: outputs checked while in reset");
    endtask

    task automatic test_round_robin();
        setup(1'b0, 2, 2, 3, 3, 28'h0100000, 28'h0200040);
        push_exp(0, 0); push_exp(1, 0); push_exp(0, 1); push_exp(1, 1);
        run(100);
        vectors++;
        if (grant_log.size() != 4 || grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 0 || grant_log[3] != 1) begin
            miscompares++;
            $display("FAIL rr_order: %0d grants logged, required order 0,1,0,1", grant_log.size());
        end
        vectors++;
        if (wr_pulses != 16) begin
            miscompares++;
            $display("FAIL rr_beats: %0d beats, required 16", wr_pulses);
        end
        $display("test_round_robin: %0d bursts granted", grant_log.size());
    endtask

    task automatic test_single();
        setup(1'b0, 1, 0, 0, 0, 28'h0001234, 28'h0);
        exp_q.push_back('{0, 28'h0001220, 4'd0});
        run(30);
        vectors++;
        if (first_aw != 1 || busy_cycles != 2 || wr_pulses != 1) begin
            miscompares++;
            $display("FAIL single_timing: first_aw=%0d busy=%0d beats=%0d, required 1 2 1", first_aw, busy_cycles, wr_pulses);
        end
        $display("test_single: busy %0d cycles, %0d beat", busy_cycles, wr_pulses);
    endtask

    task automatic test_fixed_priority();
        setup(1'b1, 3, 2, 1, 2, 28'h0300010, 28'h0310020);
        push_exp(0, 0); push_exp(0, 1); push_exp(0, 2); push_exp(1, 0); push_exp(1, 1);
        run(100);
        vectors++;
        if (grant_log.size() != 5 || grant_log[2] != 0 || grant_log[3] != 1) begin
            miscompares++;
            $display("FAIL fixed_order: %0d grants logged, required 0,0,0,1,1", grant_log.size());
        end
        $display("test_fixed_priority: %0d bursts granted", grant_log.size());
    endtask

    task automatic test_aw_stall();
        aw_delay = 5;
        setup(1'b0, 0, 1, 0, 2, 28'h0, 28'h0ABCDEF);
        push_exp(1, 0);
        run(40);
        aw_delay = 0;
        vectors++;
        if (cr_pulses != 1 || busy_cycles != 9) begin
            miscompares++;
            $display("FAIL aw_stall: cmd_ready pulses=%0d busy=%0d, required 1 and 9", cr_pulses, busy_cycles);
        end
        $display("test_aw_stall: busy %0d cycles", busy_cycles);
    endtask

    task automatic test_len15_toggle();
        wr_toggle = 1;
        setup(1'b0, 1, 0, 15, 0, 28'h0400000, 28'h0);
        push_exp(0, 0);
        run(80);
        wr_toggle = 0;
        vectors++;
        if (last_data_cycles != 31 || wr_pulses != 16) begin
            miscompares++;
            $display("FAIL len15: data cycles=%0d beats=%0d, required 31 and 16", last_data_cycles, wr_pulses);
        end
        $display("test_len15_toggle: %0d beats in %0d data cycles", wr_pulses, last_data_cycles);
    endtask

    task automatic test_reset_mid_burst();
        bit hit;
        setup(1'b0, 1, 0, 3, 0, 28'h0500000, 28'h0);
        push_exp(0, 0);
        drive_inputs();
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cycle();
            hit = (d_owner >= 0 && d_beat == 2);
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL reset_mid_reach: beat 2 never reached, required within 20 cycles");
        end
        rst = 1'b1;
        #1;
        check_zero("reset_mid_immediate");
        exp_q.delete();
        d_owner = -1; aw_held = 1'b0; aw_wait = 0;
        rem[0] = 0; rem[1] = 0;
        drive_inputs();
        @(posedge clk);
        #1;
        check_zero("reset_mid_held");
        @(negedge clk);
        rst = 1'b0;
        setup(1'b0, 1, 1, 0, 0, 28'h0600000, 28'h0610000);
        push_exp(0, 0); push_exp(1, 0);
        run(40);
        vectors++;
        if (grant_log.size() == 0 || grant_log[0] != 0) begin
            miscompares++;
            $display("FAIL reset_first_tie: first owner=%0d, required 0", grant_log.size() ? grant_log[0] : -1);
        end
        $display("test_reset_mid_burst: %0d bursts after reset", grant_log.size());
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_fixed_priority();
        test_aw_stall();
        test_len15_toggle();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
